// File: rtl/m72_pic.sv
// m72_pic: uPD71059/8259-compatible interrupt controller subset for the M72
// main CPU. Edge-triggered single mode, fixed priority (level 0 highest),
// mask register, non-specific/specific EOI and optional auto-EOI.
`timescale 1ns/1ps
module m72_pic #(
  parameter int         NUM_IR       = 8,
  parameter logic [2:0] SPURIOUS_LVL = 3'd7
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cs,
  input  logic       a0,
  input  logic       we,
  input  logic       stb,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic [7:0] ir,
  output logic       int_rq,
  input  logic       int_ack,
  output logic [7:0] vector,
  output logic       vector_valid
);

  typedef enum logic [1:0] {UNINIT, WAIT_ICW2, WAIT_ICW4, READY} init_state_t;

  init_state_t state, state_next;

  logic [7:0] irr, isr, imr, icw2, ir_q;
  logic [7:0] irr_next, isr_next;
  logic       ic4, aeoi, rd_sel;
  logic       wr_q, ack_q;

  // Decoded register-write actions for the current cycle.
  logic icw1, icw2_wr, icw4_wr, imr_wr, eoi_ns, eoi_sp, ocw3_wr;

  // Returns {found, index} of the lowest set bit (highest priority).
  function automatic logic [3:0] lowest_set(input logic [7:0] v);
    logic [3:0] r;
    r = 4'b0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  // Bus strobes; writes and acks act only on the first cycle of a stretched strobe.
  logic wr_stb, rd_stb, ack_stb, wr_pulse, ack_pulse;
  assign wr_stb    = cs & stb & we;
  assign rd_stb    = cs & stb & ~we;
  assign ack_stb   = int_ack & stb;
  assign wr_pulse  = wr_stb & ~wr_q;
  assign ack_pulse = ack_stb & ~ack_q;

  logic       ready;
  logic [7:0] ir_edge;
  logic [3:0] p_enc, s_enc;
  logic       p_valid, s_valid, ack_real;
  logic [2:0] p_lvl, s_lvl, ack_lvl;

  assign ready    = (state == READY);
  assign ir_edge  = ir & ~ir_q;
  assign p_enc    = lowest_set(irr & ~imr);
  assign s_enc    = lowest_set(isr);
  assign p_valid  = p_enc[3];
  assign p_lvl    = p_enc[2:0];
  assign s_valid  = s_enc[3];
  assign s_lvl    = s_enc[2:0];
  assign ack_real = ack_pulse & p_valid;
  assign ack_lvl  = p_valid ? p_lvl : SPURIOUS_LVL;

  // Init FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= UNINIT;
    else          state <= state_next;
  end

  // Init FSM next state and decode of ICW/OCW writes.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
    state_next = state;
    icw1       = 1'b0;
    icw2_wr    = 1'b0;
    icw4_wr    = 1'b0;
    imr_wr     = 1'b0;
    eoi_ns     = 1'b0;
    eoi_sp     = 1'b0;
    ocw3_wr    = 1'b0;
    if (wr_pulse) begin
      if (!a0 && din[4]) begin
        icw1       = 1'b1;
        state_next = WAIT_ICW2;
      end else begin
        unique case (state)
          WAIT_ICW2: if (a0) begin
            icw2_wr    = 1'b1;
            state_next = ic4 ? WAIT_ICW4 : READY;
          end
          WAIT_ICW4: if (a0) begin
            icw4_wr    = 1'b1;
            state_next = READY;
          end
          READY: begin
            if (a0) imr_wr = 1'b1;
            else if (din[4:3] == 2'b00) begin
              eoi_ns = (din[6:5] == 2'b01);
              eoi_sp = (din[6:5] == 2'b11);
            end else if (din[4:3] == 2'b01) begin
              ocw3_wr = din[1];
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Next IRR/ISR: clears first, then sets, so a coincident set wins; ICW1 overrides all.
  always_comb begin
    irr_next = irr;
    isr_next = isr;
    if (ack_real) irr_next[ack_lvl] = 1'b0;
    if (ready) irr_next = irr_next | ir_edge;
    if (eoi_ns && s_valid) isr_next[s_lvl] = 1'b0;
    if (eoi_sp) isr_next[din[2:0]] = 1'b0;
    if (ack_real && !aeoi) isr_next[ack_lvl] = 1'b1;
    if (icw1) begin
      irr_next = 8'h00;
      isr_next = 8'h00;
    end
  end

  // Request, in-service, mask and configuration registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      irr    <= 8'h00;
      isr    <= 8'h00;
      imr    <= 8'h00;
      icw2   <= 8'h00;
      ir_q   <= 8'h00;
      ic4    <= 1'b0;
      aeoi   <= 1'b0;
      rd_sel <= 1'b0;
      wr_q   <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      irr   <= irr_next;
      isr   <= isr_next;
      ir_q  <= ir;
      wr_q  <= wr_stb;
      ack_q <= ack_stb;
      if (icw1) begin
        imr <= 8'h00;
        ic4 <= din[0];
      end else if (imr_wr) begin
        imr <= din;
      end
      if (icw2_wr) begin
        icw2 <= din;
        if (!ic4) aeoi <= 1'b0;
      end
      if (icw4_wr) aeoi <= din[1];
      if (ocw3_wr) rd_sel <= din[0];
    end
  end

  // Registered request to the CPU; forced low on the acknowledge edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) int_rq <= 1'b0;
    else if (ack_pulse) int_rq <= 1'b0;
    else int_rq <= ready & p_valid & (!s_valid | (p_lvl < s_lvl));
  end

  // Vector latch: captured on the ack edge, valid until int_ack falls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vector       <= 8'h00;
      vector_valid <= 1'b0;
    end else if (ack_pulse) begin
      vector       <= {icw2[7:3], ack_lvl};
      vector_valid <= 1'b1;
    end else if (!int_ack) begin
      vector_valid <= 1'b0;
    end
  end

  // Registered register-read port.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dout       <= 8'h00;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= rd_stb;
      if (rd_stb) dout <= a0 ? imr : (rd_sel ? isr : irr);
    end
  end

endmodule

// File: tb/tb_m72_pic.sv
// Directed self-checking bench for m72_pic. Inputs change on the falling
// edge; outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_m72_pic;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cs = 1'b0, a0 = 1'b0, we = 1'b0, stb = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       dout_valid;
  logic [7:0] ir = 8'h00;
  logic       int_rq;
  logic       int_ack = 1'b0;
  logic [7:0] vector;
  logic       vector_valid;

  int checks = 0;
  int errors = 0;

  m72_pic dut (
    .clock(clock), .reset_n(reset_n), .cs(cs), .a0(a0), .we(we), .stb(stb),
    .din(din), .dout(dout), .dout_valid(dout_valid), .ir(ir), .int_rq(int_rq),
    .int_ack(int_ack), .vector(vector), .vector_valid(vector_valid)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  task automatic bus_write(input logic a, input logic [7:0] d);
    cs = 1'b1; stb = 1'b1; we = 1'b1; a0 = a; din = d;
    @(negedge clock);
    cs = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clock);
  endtask

  task automatic bus_read(input logic a, output logic [7:0] d, output logic v);
    cs = 1'b1; stb = 1'b1; we = 1'b0; a0 = a;
    @(negedge clock);
    d = dout; v = dout_valid;
    cs = 1'b0; stb = 1'b0;
    @(negedge clock);
  endtask

  task automatic pulse_ir(input int i);
    ir[i] = 1'b1;
    @(negedge clock);
    ir[i] = 1'b0;
  endtask

  task automatic ack_begin();
    int_ack = 1'b1; stb = 1'b1;
    @(negedge clock);
  endtask

  task automatic ack_end();
    int_ack = 1'b0; stb = 1'b0;
    @(negedge clock);
  endtask

  task automatic init_pic(input logic [7:0] icw4);
    bus_write(1'b0, 8'h13);
    bus_write(1'b1, 8'h20);
    bus_write(1'b1, icw4);
    bus_write(1'b1, 8'h00);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checks++; if (int_rq !== 1'b0) begin errors++; $display("FAIL reset_int_rq got %b exp 0", int_rq); end
    checks++; if (vector !== 8'h00) begin errors++; $display("FAIL reset_vector got %h exp 00", vector); end
    checks++; if (vector_valid !== 1'b0) begin errors++; $display("FAIL reset_vector_valid got %b exp 0", vector_valid); end
    checks++; if ({dout_valid, dout} !== 9'h000) begin errors++; $display("FAIL reset_dout got %b/%h exp 0/00", dout_valid, dout); end
  endtask

  task automatic test_init();
    logic [7:0] d; logic v;
    init_pic(8'h01);
    pulse_ir(0);
    checks++; if (int_rq !== 1'b0) begin errors++; $display("FAIL init_rq_early got %b exp 0", int_rq); end
    @(negedge clock);
    checks++; if (int_rq !== 1'b1) begin errors++; $display("FAIL init_rq got %b exp 1", int_rq); end
    ack_begin();
    checks++; if (vector !== 8'h20 || vector_valid !== 1'b1) begin errors++; $display("FAIL init_vector got %h/%b exp 20/1", vector, vector_valid); end
    checks++; if (int_rq !== 1'b0) begin errors++; $display("FAIL init_rq_after_ack got %b exp 0", int_rq); end
    ack_end();
    checks++; if (vector_valid !== 1'b0 || vector !== 8'h20) begin errors++; $display("FAIL init_vector_release got %h/%b exp 20/0", vector, vector_valid); end
    bus_write(1'b0, 8'h0B);
    bus_read(1'b0, d, v);
    checks++; if (d !== 8'h01 || v !== 1'b1) begin errors++; $display("FAIL init_isr got %h/%b exp 01/1", d, v); end
    bus_write(1'b0, 8'h0A);
    bus_read(1'b0, d, v);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL init_irr got %h exp 00", d); end
    bus_write(1'b0, 8'h20);
  endtask

  task automatic test_nesting();
    logic [7:0] d; logic v;
    pulse_ir(2);
    @(negedge clock);
    ack_begin();
    checks++; if (vector !== 8'h22) begin errors++; $display("FAIL nest_vec2 got %h exp 22", vector); end
    ack_end();
    pulse_ir(4);
    @(negedge clock);
    checks++; if (int_rq !== 1'b0) begin errors++; $display("FAIL nest_lower_blocked got %b exp 0", int_rq); end
    pulse_ir(0);
    @(negedge clock);
    checks++; if (int_rq !== 1'b1) begin errors++; $display("FAIL nest_higher_rq got %b exp 1", int_rq); end
    ack_begin();
    checks++; if (vector !== 8'h20) begin errors++; $display("FAIL nest_vec0 got %h exp 20", vector); end
    ack_end();
    bus_write(1'b0, 8'h0B);
    bus_read(1'b0, d, v);
    checks++; if (d !== 8'h05) begin errors++; $display("FAIL nest_isr05 got %h exp 05", d); end
    bus_write(1'b0, 8'h20);
    bus_read(1'b0, d, v);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL nest_isr04 got %h exp 04", d); end
    checks++; if (int_rq !== 1'b0) begin errors++; $display("FAIL nest_rq_under_isr2 got %b exp 0", int_rq); end
    bus_write(1'b0, 8'h0A);
    bus_read(1'b0, d, v);
    checks++; if (d !== 8'h10) begin errors++; $display("FAIL nest_irr10 got %h exp 10", d); end
    bus_write(1'b0, 8'h20);
    checks++; if (int_rq !== 1'b1) begin errors++; $display("FAIL nest_rq_level4 got %b exp 1", int_rq); end
    ack_begin();
    checks++; if (vector !== 8'h24) begin errors++; $display("FAIL nest_vec4 got %h exp 24", vector); end
    ack_end();
    bus_write(1'b0, 8'h64);
    bus_write(1'b0, 8'h0B);
    bus_read(1'b0, d, v);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL nest_specific_eoi got %h exp 00", d); end
  endtask

  task automatic test_mask();
    logic [7:0] d; logic v;
    bus_write(1'b1, 8'h01);
    pulse_ir(0);
    @(negedge clock);
    checks++; if (int_rq !== 1'b0) begin errors++; $display("FAIL mask_rq got %b exp 0", int_rq); end
    bus_write(1'b0, 8'h0A);
    bus_read(1'b0, d, v);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL mask_irr got %h exp 01", d); end
    bus_read(1'b1, d, v);
    checks++; if (d !== 8'h01 || v !== 1'b1) begin errors++; $display("FAIL mask_imr got %h/%b exp 01/1", d, v); end
    bus_write(1'b1, 8'h00);
    checks++; if (int_rq !== 1'b1) begin errors++; $display("FAIL mask_unmask_rq got %b exp 1", int_rq); end
    ack_begin();
    checks++; if (vector !== 8'h20) begin errors++; $display("FAIL mask_vec got %h exp 20", vector); end
    ack_end();
    bus_write(1'b0, 8'h20);
  endtask

  task automatic test_aeoi();
    logic [7:0] d; logic v;
    init_pic(8'h03);
    pulse_ir(2);
    @(negedge clock);
    ack_begin();
    checks++; if (vector !== 8'h22) begin errors++; $display("FAIL aeoi_vec got %h exp 22", vector); end
    ack_end();
    bus_write(1'b0, 8'h0B);
    bus_read(1'b0, d, v);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL aeoi_isr got %h exp 00", d); end
  endtask

  task automatic test_spurious();
    logic [7:0] d; logic v;
    ack_begin();
    checks++; if (vector !== 8'h27 || vector_valid !== 1'b1) begin errors++; $display("FAIL spur_vec got %h/%b exp 27/1", vector, vector_valid); end
    ack_end();
    bus_read(1'b0, d, v);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL spur_isr got %h exp 00", d); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d; logic v;
    pulse_ir(0);
    @(negedge clock);
    ir[0] = 1'b1; int_ack = 1'b1; stb = 1'b1;
    @(negedge clock);
    ir[0] = 1'b0;
    checks++; if (vector !== 8'h20) begin errors++; $display("FAIL coinc_vec got %h exp 20", vector); end
    ack_end();
    checks++; if (int_rq !== 1'b1) begin errors++; $display("FAIL coinc_rq got %b exp 1", int_rq); end
    bus_write(1'b0, 8'h0A);
    bus_read(1'b0, d, v);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL coinc_irr got %h exp 01", d); end
    ack_begin();
    ack_end();
  endtask

  task automatic test_reset_mid_ack();
    logic [7:0] d; logic v;
    pulse_ir(2);
    @(negedge clock);
    ack_begin();
    checks++; if (vector_valid !== 1'b1) begin errors++; $display("FAIL rma_valid got %b exp 1", vector_valid); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (vector_valid !== 1'b0 || vector !== 8'h00 || int_rq !== 1'b0) begin errors++; $display("FAIL rma_cleared got %h/%b/%b exp 00/0/0", vector, vector_valid, int_rq); end
    int_ack = 1'b0; stb = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    pulse_ir(0);
    @(negedge clock);
    checks++; if (int_rq !== 1'b0) begin errors++; $display("FAIL rma_uninit_rq got %b exp 0", int_rq); end
    bus_read(1'b0, d, v);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL rma_uninit_irr got %h exp 00", d); end
    init_pic(8'h01);
    pulse_ir(0);
    @(negedge clock);
    checks++; if (int_rq !== 1'b1) begin errors++; $display("FAIL rma_reinit_rq got %b exp 1", int_rq); end
    ack_begin();
    checks++; if (vector !== 8'h20) begin errors++; $display("FAIL rma_reinit_vec got %h exp 20", vector); end
    ack_end();
  endtask

  initial begin
    test_reset();
    test_init();
    test_nesting();
    test_mask();
    test_aeoi();
    test_spurious();
    test_back_to_back();
    test_reset_mid_ack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
